// File: rtl/edge_event_logger_pkg.sv
// Shared types and constants for the edge event logger.
// event_t shows the {pol, ts} layout at the default timestamp width.
package edge_event_pkg;

    localparam int CNT_W    = 8;
    localparam int TS_W_DEF = 8;

    typedef struct packed {
        logic                pol;
        logic [TS_W_DEF-1:0] ts;
    } event_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/edge_event_logger_if.sv
// Event stream handshake between the logger and its consumer.
// The master presents the FIFO head; the slave drives ready.
interface edge_event_logger_if #(
    parameter int TS_W = 8
);
    logic            evt_valid;
    logic            evt_ready;
    logic            evt_pol;
    logic [TS_W-1:0] evt_ts;

    modport master (
        output evt_valid,
        output evt_pol,
        output evt_ts,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_pol,
        input  evt_ts,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_logger_fifo.sv
// Event FIFO: power-of-two ring buffer with wrap-bit pointers.
// A push while full only lands when a pop frees the head slot.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         wr_en;
    logic         rd_en;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    // Pointer advance; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
        end
    end

    // Storage write; contents are meaningless until pointed at.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/edge_event_logger.sv
// Edge event logger: samples sig_in, timestamps each edge into a
// FIFO and keeps saturating rise/fall counts plus a sticky overflow.
module edge_event_logger
    import edge_event_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sig_in,
    input  logic                      clr,
    edge_event_logger_if.master       evt,
    output logic [CNT_W-1:0]          rise_cnt,
    output logic [CNT_W-1:0]          fall_cnt,
    output logic                      overflow
);
    logic             sig_q;
    logic [TS_W-1:0]  ts_q;
    logic [CNT_W-1:0] rise_q, rise_d;
    logic [CNT_W-1:0] fall_q, fall_d;
    logic             ovf_q, ovf_d;

    logic             rise;
    logic             fall;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [TS_W:0]    din;
    logic [TS_W:0]    dout;

    assign rise = sig_in && !sig_q;
    assign fall = !sig_in && sig_q;
    assign push = rise || fall;
    assign pop  = !empty && evt.evt_ready;
    assign din  = {rise, ts_q};

    event_fifo #(
        .DEPTH (DEPTH),
        .W     (TS_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (din),
        .dout_o  (dout),
        .full_o  (full),
        .empty_o (empty)
    );

    assign evt.evt_valid = !empty;
    assign evt.evt_pol   = dout[TS_W];
    assign evt.evt_ts    = dout[TS_W-1:0];

    assign rise_cnt = rise_q;
    assign fall_cnt = fall_q;
    assign overflow = ovf_q;

    // Next-state for counters and overflow; clr beats increments.
    always_comb begin
        rise_d = rise_q;
        fall_d = fall_q;
        ovf_d  = ovf_q;
        if (clr) begin
            rise_d = '0;
            fall_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (rise) rise_d = sat_inc(rise_q);
            if (fall) fall_d = sat_inc(fall_q);
            if (push && full && !pop) ovf_d = 1'b1;
        end
    end

    // Sample input, run the timestamp and commit status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q  <= 1'b0;
            ts_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            sig_q  <= sig_in;
            ts_q   <= ts_q + 1'b1;
            rise_q <= rise_d;
            fall_q <= fall_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_edge_event_logger.sv
// Bench for edge_event_logger: directed edges, expected events
// queued at stimulus time and checked by an independent monitor.
module tb_edge_event_logger;
    import edge_event_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       sig_in;
    logic       clr;
    logic [7:0] rise_cnt;
    logic [7:0] fall_cnt;
    logic       overflow;

    edge_event_logger_if #(.TS_W(8)) evt_bus ();

    edge_event_logger #(
        .DEPTH (4),
        .TS_W  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .clr      (clr),
        .evt      (evt_bus),
        .rise_cnt (rise_cnt),
        .fall_cnt (fall_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int     tests = 0;
    int     fails = 0;
    event_t sb[$];
    logic   last_sig;
    logic [7:0] m_ts;

    // Reference timestamp: the value the logger holds between edges.
    always @(posedge clk) begin
        if (rst) m_ts <= 8'd0;
        else     m_ts <= m_ts + 8'd1;
    end

    // Monitor: every accepted head event is compared to the queue.
    always @(negedge clk) begin
        event_t e;
        if (rst === 1'b0 && evt_bus.evt_valid === 1'b1 &&
            evt_bus.evt_ready === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event got pol=%0d ts=%0d expected none",
                         evt_bus.evt_pol, evt_bus.evt_ts);
            end else begin
                e = sb.pop_front();
                if (evt_bus.evt_pol !== e.pol || evt_bus.evt_ts !== e.ts) begin
                    fails++;
                    $display("FAIL event got pol=%0d ts=%0d expected pol=%0d ts=%0d",
                             evt_bus.evt_pol, evt_bus.evt_ts, e.pol, e.ts);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive a level for one cycle; keep=0 marks an edge that is dropped.
    task automatic set_sig(input logic v, input bit keep);
        event_t e;
        if (v != last_sig && keep) begin
            e.pol = v;
            e.ts  = m_ts;
            sb.push_back(e);
        end
        sig_in   = v;
        last_sig = v;
        step();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            step();
            n++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        sig_in            = 1'b1;
        last_sig          = 1'b1;
        clr               = 1'b0;
        evt_bus.evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        at_neg();
        check("rst_valid", evt_bus.evt_valid, 0);
        check("rst_rise", rise_cnt, 0);
        check("rst_fall", fall_cnt, 0);
        check("rst_ovf", overflow, 0);

        // Release with sig_in high: one rise at ts 0.
        step();
        rst = 1'b0;
        begin
            event_t e;
            e.pol = 1'b1;
            e.ts  = 8'd0;
            sb.push_back(e);
        end
        step();
        at_neg();
        check("first_valid", evt_bus.evt_valid, 1);
        check("first_rise", rise_cnt, 1);
        step();
        wait_drain(10);

        // Four alternating edges, consecutive timestamps.
        pulse_clr();
        at_neg();
        check("clr_rise", rise_cnt, 0);
        step();
        set_sig(1'b0, 1);
        set_sig(1'b1, 1);
        set_sig(1'b0, 1);
        set_sig(1'b1, 1);
        at_neg();
        check("alt_rise", rise_cnt, 2);
        check("alt_fall", fall_cnt, 2);
        step();
        wait_drain(10);

        // Sub-cycle glitch is invisible.
        set_sig(1'b0, 1);
        wait_drain(10);
        pulse_clr();
        #1 sig_in = 1'b1;
        #1 sig_in = 1'b0;
        repeat (3) step();
        at_neg();
        check("glitch_rise", rise_cnt, 0);
        check("glitch_fall", fall_cnt, 0);
        check("glitch_valid", evt_bus.evt_valid, 0);
        step();

        // Six edges into a four-entry FIFO with ready low.
        evt_bus.evt_ready = 1'b0;
        set_sig(1'b1, 1);
        set_sig(1'b0, 1);
        set_sig(1'b1, 1);
        set_sig(1'b0, 1);
        set_sig(1'b1, 0);
        set_sig(1'b0, 0);
        step();
        at_neg();
        check("ovf_set", overflow, 1);
        check("ovf_total", rise_cnt + fall_cnt, 6);
        check("ovf_head_pol", evt_bus.evt_pol, 1);
        step();
        evt_bus.evt_ready = 1'b1;
        wait_drain(20);
        check("ovf_sticky", overflow, 1);

        // Full FIFO with same-cycle pop and push.
        pulse_clr();
        at_neg();
        check("ovf_clr", overflow, 0);
        step();
        evt_bus.evt_ready = 1'b0;
        set_sig(1'b1, 1);
        set_sig(1'b0, 1);
        set_sig(1'b1, 1);
        set_sig(1'b0, 1);
        step();
        evt_bus.evt_ready = 1'b1;
        set_sig(1'b1, 1);
        evt_bus.evt_ready = 1'b0;
        at_neg();
        check("full_pp_ovf", overflow, 0);
        step();
        set_sig(1'b0, 0);
        at_neg();
        check("full_still4", overflow, 1);
        step();
        evt_bus.evt_ready = 1'b1;
        wait_drain(20);

        // Saturation, then clr racing an edge.
        pulse_clr();
        for (int i = 0; i < 300; i++) begin
            set_sig(1'b1, 1);
            set_sig(1'b0, 1);
        end
        at_neg();
        check("sat_rise", rise_cnt, 255);
        check("sat_fall", fall_cnt, 255);
        step();
        clr = 1'b1;
        set_sig(1'b1, 1);
        clr = 1'b0;
        at_neg();
        check("clr_race_rise", rise_cnt, 0);
        check("clr_race_fall", fall_cnt, 0);
        check("clr_race_valid", evt_bus.evt_valid, 1);
        step();
        wait_drain(10);

        // Reset discards queued events.
        evt_bus.evt_ready = 1'b0;
        set_sig(1'b0, 1);
        set_sig(1'b1, 1);
        at_neg();
        check("pre_rst_valid", evt_bus.evt_valid, 1);
        step();
        rst      = 1'b1;
        sig_in   = 1'b0;
        last_sig = 1'b0;
        step();
        sb.delete();
        at_neg();
        check("mid_rst_valid", evt_bus.evt_valid, 0);
        check("mid_rst_rise", rise_cnt, 0);
        step();
        rst = 1'b0;
        evt_bus.evt_ready = 1'b1;
        repeat (3) step();
        at_neg();
        check("post_rst_valid", evt_bus.evt_valid, 0);
        check("post_rst_ovf", overflow, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
